enemy_hit_judge_multi: RTL

ENEMY_HIT_JUDGE_MULTI -- requirements
Module: enemy_hit_judge_multi

---
 rtl/enemy_hit_judge_multi.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/enemy_hit_judge_multi.sv
// Multi-channel bullet/enemy hit judge with per-channel ALIVE/BOOM/REVIVE sequencing.
// Optional macro ENEMY_HIT_SCORE_EN adds a saturating 16-bit score output.
module enemy_hit_judge_multi #(
  parameter int N_ENEMY    = 4,
  parameter int HP_W       = 3,
  parameter int HB_L       = 10,
  parameter int HB_R       = 50,
  parameter int HB_UP      = 40,
  parameter int HB_DN      = 50,
  parameter int Y_OFF      = 480,
  parameter int RELOAD_CYC = 150000,
  parameter int BOOM_CYC   = 67108864,
  parameter int REVIVE_CYC = 375000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [10*N_ENEMY-1:0]     ep_x,
  input  logic [10*N_ENEMY-1:0]     ep_y,
  input  logic [9:0]                b_x,
  input  logic [9:0]                b_y,
  input  logic                      mybullet_en,
  input  logic [N_ENEMY-1:0]        enemy_en,
  input  logic [HP_W-1:0]           enemy_health,
  output logic                      present_mb_en,
  output logic [N_ENEMY-1:0]        boom,
  output logic [N_ENEMY-1:0]        revive,
  output logic [HP_W*N_ENEMY-1:0]   health,
  output logic                      hit_pulse,
  output logic [2:0]                hit_idx
`ifdef ENEMY_HIT_SCORE_EN
  ,
  output logic [15:0]               score
`endif
);

  localparam int DUR_MAX = (BOOM_CYC > REVIVE_CYC) ? BOOM_CYC : REVIVE_CYC;
  localparam int DUR_W   = $clog2(DUR_MAX) + 1;
  localparam int RLD_W   = $clog2(RELOAD_CYC + 2) + 1;
  localparam logic [DUR_W-1:0] BOOM_LAST = DUR_W'(BOOM_CYC - 1);
  localparam logic [DUR_W-1:0] REV_LAST  = DUR_W'(REVIVE_CYC - 1);
  localparam logic [RLD_W-1:0] RLD_LIM   = RLD_W'(RELOAD_CYC);
  localparam logic [11:0] HB_L12  = 12'(HB_L);
  localparam logic [11:0] HB_R12  = 12'(HB_R);
  localparam logic [11:0] HB_UP12 = 12'(HB_UP);
  localparam logic [11:0] HB_DN12 = 12'(HB_DN);
  localparam logic [11:0] Y_OFF12 = 12'(Y_OFF);

  typedef enum logic [1:0] {ST_ALIVE = 2'd0, ST_BOOM = 2'd1, ST_REVIVE = 2'd2} st_e;

  st_e              state_q [N_ENEMY];
  st_e              state_d [N_ENEMY];
  logic [DUR_W-1:0] dur_q   [N_ENEMY];
  logic [DUR_W-1:0] dur_d   [N_ENEMY];
  logic [HP_W-1:0]  hp_q    [N_ENEMY];
  logic [HP_W-1:0]  hp_d    [N_ENEMY];
  logic [N_ENEMY-1:0] cand_s;
  logic [N_ENEMY-1:0] boom_q, boom_d, revive_q, revive_d;
  logic [RLD_W-1:0] rld_q, rld_d;
  logic             pres_q, pres_d;
  logic             hit_pulse_q, hit_pulse_d;
  logic [2:0]       hit_idx_q, hit_idx_d;
  logic             win_s;
  logic [2:0]       win_idx_s;
  logic [11:0]      bx_s, by_s;

  assign bx_s = {2'b00, b_x};
  assign by_s = {2'b00, b_y};

  // All geometry is 12-bit so the hitbox edges never wrap around zero or 1023.
  for (genvar g = 0; g < N_ENEMY; g++) begin : g_ch
    logic [11:0] ex_s, ey_s;
    logic        hit_s;
    assign ex_s  = {2'b00, ep_x[10*g +: 10]};
    assign ey_s  = {2'b00, ep_y[10*g +: 10]} + Y_OFF12;
    assign hit_s = (bx_s + HB_L12 >= ex_s) && (bx_s < ex_s + HB_R12) &&
                   (by_s + HB_UP12 > ey_s) && (by_s < ey_s + HB_DN12);
    assign cand_s[g] = pres_q & enemy_en[g] & (state_q[g] == ST_ALIVE) &
                       (hp_q[g] != '0) & hit_s;
    assign health[HP_W*g +: HP_W] = hp_q[g];
  end

  // Lowest-index eligible channel wins the bullet.
  always_comb begin
    win_s     = |cand_s;
    win_idx_s = 3'd0;
    for (int i = N_ENEMY - 1; i >= 0; i--) begin
      win_idx_s = cand_s[i] ? 3'(i) : win_idx_s;
    end
  end

  // Per-channel health and ALIVE/BOOM/REVIVE sequencing.
  always_comb begin
    for (int i = 0; i < N_ENEMY; i++) begin
      state_d[i] = state_q[i];
      dur_d[i]   = dur_q[i];
      hp_d[i]    = hp_q[i];
      case (state_q[i])
        ST_ALIVE: begin
          if (hp_q[i] == '0) begin
            state_d[i] = ST_BOOM;
            dur_d[i]   = '0;
          end else if (win_s && (win_idx_s == 3'(i))) begin
            hp_d[i] = hp_q[i] - {{(HP_W-1){1'b0}}, 1'b1};
          end else begin
            hp_d[i] = hp_q[i];
          end
        end
        ST_BOOM: begin
          if (dur_q[i] == BOOM_LAST) begin
            state_d[i] = ST_REVIVE;
            dur_d[i]   = '0;
            hp_d[i]    = enemy_health;
          end else begin
            dur_d[i] = dur_q[i] + {{(DUR_W-1){1'b0}}, 1'b1};
          end
        end
        ST_REVIVE: begin
          if (dur_q[i] == REV_LAST) begin
            state_d[i] = ST_ALIVE;
            dur_d[i]   = '0;
          end else begin
            dur_d[i] = dur_q[i] + {{(DUR_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state_d[i] = ST_ALIVE;
          dur_d[i]   = '0;
        end
      endcase
      boom_d[i]   = (state_d[i] == ST_BOOM);
      revive_d[i] = (state_d[i] == ST_REVIVE);
    end
  end

  // Bullet consumption and reload; a hit needs a live bullet, so it never collides with a reload.
  always_comb begin
    pres_d      = pres_q;
    rld_d       = rld_q;
    hit_pulse_d = win_s;
    hit_idx_d   = win_s ? win_idx_s : hit_idx_q;
    if (pres_q) begin
      pres_d = ~win_s;
      rld_d  = '0;
    end else if (rld_q > RLD_LIM) begin
      pres_d = mybullet_en;
      rld_d  = '0;
    end else begin
      rld_d = rld_q + {{(RLD_W-1){1'b0}}, 1'b1};
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pres_q      <= 1'b0;
      rld_q       <= '0;
      hit_pulse_q <= 1'b0;
      hit_idx_q   <= 3'd0;
      boom_q      <= '0;
      revive_q    <= '0;
      for (int i = 0; i < N_ENEMY; i++) begin
        state_q[i] <= ST_ALIVE;
        dur_q[i]   <= '0;
        hp_q[i]    <= enemy_health;
      end
    end else begin
      pres_q      <= pres_d;
      rld_q       <= rld_d;
      hit_pulse_q <= hit_pulse_d;
      hit_idx_q   <= hit_idx_d;
      boom_q      <= boom_d;
      revive_q    <= revive_d;
      for (int i = 0; i < N_ENEMY; i++) begin
        state_q[i] <= state_d[i];
        dur_q[i]   <= dur_d[i];
        hp_q[i]    <= hp_d[i];
      end
    end
  end

  assign present_mb_en = pres_q;
  assign boom          = boom_q;
  assign revive        = revive_q;
  assign hit_pulse     = hit_pulse_q;
  assign hit_idx       = hit_idx_q;

`ifdef ENEMY_HIT_SCORE_EN
  logic [15:0] score_q, score_d;
  logic [16:0] score_sum_s;
  logic [3:0]  boom_cnt_s;

  // +1 per registered hit, +4 per ALIVE->BOOM transition, saturating.
  always_comb begin
    boom_cnt_s = 4'd0;
    for (int i = 0; i < N_ENEMY; i++) begin
      boom_cnt_s = boom_cnt_s + (((state_q[i] == ST_ALIVE) && (hp_q[i] == '0)) ? 4'd1 : 4'd0);
    end
    score_sum_s = {1'b0, score_q} + {16'd0, win_s} + {11'd0, boom_cnt_s, 2'b00};
    if (score_sum_s[16]) begin
      score_d = 16'hFFFF;
    end else begin
      score_d = score_sum_s[15:0];
    end
  end

  // Score register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      score_q <= 16'd0;
    end else begin
      score_q <= score_d;
    end
  end

  assign score = score_q;
`endif

endmodule
